// File: rtl/mano_pkg.sv
// ============================================================================
// Module  : mano_pkg
// Brief   : Shared opcode, instruction-bit and timing constants for the
//           basic-computer timing and control block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mano_pkg;

    localparam int NUM_T = 8;
    localparam int SC_W  = 3;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_ADD    = 3'd1,
        OP_LDA    = 3'd2,
        OP_STA    = 3'd3,
        OP_BUN    = 3'd4,
        OP_BSA    = 3'd5,
        OP_ISZ    = 3'd6,
        OP_REG_IO = 3'd7
    } opcode_e;

    localparam int HLT_BIT = 0;
    localparam int IOF_BIT = 6;
    localparam int ION_BIT = 7;

    function automatic logic [NUM_T-1:0] onehot8(input logic [SC_W-1:0] v);
        return NUM_T'(1) << v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mano_seq_counter.sv
// ============================================================================
// Module  : mano_seq_counter
// Brief   : 3-bit sequence counter (hold / clear / increment) and the
//           one-hot timing decode T, forced to zero while not running.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mano_seq_counter
    import mano_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    output logic [NUM_T-1:0] t
);

    logic [SC_W-1:0] sc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc <= '0;
        end else if (run) begin
            sc <= clr ? '0 : sc + 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_T; i++) begin : g_tdec
            assign t[i] = run && (sc == SC_W'(i));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mano_timing_control.sv
// ============================================================================
// Module  : mano_timing_control
// Brief   : Timing and control sequencer: SC/T decode, D/I decode latch,
//           run flag S, interrupt cycle R and IEN. Define SINGLE_STEP_EN to
//           add a step input that runs one instruction/interrupt cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mano_timing_control #(
    parameter int NUM_T        = 8,
    parameter bit RUN_AT_RESET = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             start,
    input  logic [15:0]      ir,
    input  logic             fgi,
    input  logic             fgo,
    output logic [NUM_T-1:0] T,
    output logic [7:0]       D,
    output logic             I,
    output logic             R,
    output logic             IEN,
    output logic             S,
    output logic             sc_clr
);

    import mano_pkg::*;

    logic reg_ref;
    logic io_ref;
    logic hlt;
    logic set_r;
    logic int_done;
    logic decode_en;
    logic unused_ir_bits;

    mano_seq_counter u_seq_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (S),
        .clr   (sc_clr),
        .t     (T)
    );

    assign reg_ref   = D[OP_REG_IO] & ~I & T[3];
    assign io_ref    = D[OP_REG_IO] &  I & T[3];
    assign hlt       = reg_ref & ir[HLT_BIT];
    assign int_done  = R & T[2];
    assign decode_en = ~R & T[2];

    // T0..T2 are excluded so an interrupt never lands before the fetch completes
    assign set_r = S & ~(T[0] | T[1] | T[2]) & IEN & (fgi | fgo) & ~R;

    assign sc_clr = int_done | reg_ref | io_ref
                  | ((D[OP_AND] | D[OP_ADD] | D[OP_LDA]) & T[5])
                  | ((D[OP_STA] | D[OP_BUN]) & T[4])
                  | (D[OP_BSA] & T[5])
                  | (D[OP_ISZ] & T[6]);

    assign unused_ir_bits = ^{ir[11:8], ir[5:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D <= 8'h01;
            I <= 1'b0;
        end else if (decode_en) begin
            D <= onehot8(ir[14:12]);
            I <= ir[15];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R   <= 1'b0;
            IEN <= 1'b0;
        end else begin
            if (int_done) begin
                R <= 1'b0;
            end else if (set_r) begin
                R <= 1'b1;
            end
            // IOF takes priority when both ION and IOF bits are present
            if (int_done || (io_ref && ir[IOF_BIT])) begin
                IEN <= 1'b0;
            end else if (io_ref && ir[ION_BIT]) begin
                IEN <= 1'b1;
            end
        end
    end

`ifdef SINGLE_STEP_EN
    logic step_d;
    logic step_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S         <= RUN_AT_RESET;
            step_d    <= 1'b0;
            step_mode <= 1'b0;
        end else begin
            step_d <= step;
            if (hlt) begin
                S         <= 1'b0;
                step_mode <= 1'b0;
            end else if (!S && start) begin
                S         <= 1'b1;
                step_mode <= 1'b0;
            end else if (!S && step && !step_d) begin
                S         <= 1'b1;
                step_mode <= 1'b1;
            end else if (S && step_mode && sc_clr) begin
                S         <= 1'b0;
                step_mode <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S <= RUN_AT_RESET;
        end else if (hlt) begin
            S <= 1'b0;
        end else if (!S && start) begin
            S <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire
